// File: rtl/mem_port_arbiter_if.sv
// Bundle of signals between the core's fetch/data ports, the arbiter and the RAM.
// The arbiter connects through the slave modport; the core/RAM side uses master.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [BE_W-1:0]   d_be;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_en;
  logic [BE_W-1:0]   mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_ack, if_rdata,
    input  d_req, d_we, d_be, d_addr, d_wdata,
    output d_ack, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_ack, if_rdata,
    output d_req, d_we, d_be, d_addr, d_wdata,
    input  d_ack, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between the
// instruction-fetch and load/store ports; one RAM access outstanding at a time.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no transaction; pick a winner when any request is present
// ST_ISSUE | mem_en high for one cycle with the captured access
// ST_WAIT  | read in flight; latency down-counter runs to terminal count
// ST_RESP  | one-cycle ack to the winner, then back to idle
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input logic                clk,
  input logic                resetn,
  mem_port_arbiter_if.slave  bus
);
  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t            state;
  logic              last_d;
  logic              win_d;
  logic              win_we;
  logic [CNT_W-1:0]  cnt;
  logic              grant_d;

  logic              mem_en_q;
  logic [BE_W-1:0]   mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              if_ack_q;
  logic              d_ack_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;

  // On a tie the port that did not win last time gets the RAM.
  assign grant_d = bus.d_req && (!bus.if_req || !last_d);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      last_d      <= 1'b1;
      win_d       <= 1'b0;
      win_we      <= 1'b0;
      cnt         <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.if_req || bus.d_req) begin
            win_d       <= grant_d;
            last_d      <= grant_d;
            win_we      <= grant_d && bus.d_we;
            mem_en_q    <= 1'b1;
            mem_addr_q  <= grant_d ? bus.d_addr : bus.if_addr;
            mem_we_q    <= (grant_d && bus.d_we) ? bus.d_be : '0;
            mem_wdata_q <= grant_d ? bus.d_wdata : '0;
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          mem_en_q <= 1'b0;
          mem_we_q <= '0;
          if (win_we) begin
            d_ack_q <= 1'b1;
            state   <= ST_RESP;
          end else begin
            cnt   <= CNT_W'(MEM_LATENCY);
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt <= cnt - 1'b1;
          // Last count: mem_rdata is valid in this cycle only.
          if (cnt == CNT_W'(1)) begin
            if (win_d) begin
              d_rdata_q <= bus.mem_rdata;
              d_ack_q   <= 1'b1;
            end else begin
              if_rdata_q <= bus.mem_rdata;
              if_ack_q   <= 1'b1;
            end
            state <= ST_RESP;
          end
        end
        ST_RESP: begin
          if_ack_q <= 1'b0;
          d_ack_q  <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: latency-1 arbiter with a behavioural RAM, plus a latency-3
// instance whose read data is driven valid in exactly one cycle.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] ram [0:255];

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b5 ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) dut (
    .clk(clk), .resetn(resetn), .bus(b1));
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3)) dut5 (
    .clk(clk), .resetn(resetn), .bus(b5));

  always @(posedge clk) begin
    if (b1.mem_en) begin
      for (int i = 0; i < 4; i++)
        if (b1.mem_we[i]) ram[b1.mem_addr[9:2]][8*i +: 8] <= b1.mem_wdata[8*i +: 8];
      b1.mem_rdata <= ram[b1.mem_addr[9:2]];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic d_txn(input logic we, input logic [3:0] be, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] exp_we,
                       input logic [31:0] exp_rd, input string tag);
    b1.d_req = 1'b1; b1.d_we = we; b1.d_be = be; b1.d_addr = addr; b1.d_wdata = wdata;
    tick();
    chk({tag, "_mem_en"}, 64'(b1.mem_en), 64'd1);
    chk({tag, "_mem_we"}, 64'(b1.mem_we), 64'(exp_we));
    chk({tag, "_mem_addr"}, 64'(b1.mem_addr), 64'(addr));
    if (we) chk({tag, "_mem_wdata"}, 64'(b1.mem_wdata), 64'(wdata));
    tick();
    if (!we) begin
      chk({tag, "_early_ack"}, 64'(b1.d_ack), 64'd0);
      tick();
    end
    chk({tag, "_d_ack"}, 64'(b1.d_ack), 64'd1);
    chk({tag, "_if_ack"}, 64'(b1.if_ack), 64'd0);
    chk({tag, "_en_low"}, 64'(b1.mem_en), 64'd0);
    if (!we) chk({tag, "_d_rdata"}, 64'(b1.d_rdata), 64'(exp_rd));
    b1.d_req = 1'b0;
    tick();
    chk({tag, "_ack_pulse"}, 64'(b1.d_ack), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'h0;
    ram[4] = 32'h00500093;
    ram[5] = 32'h00100113;
    b1.if_req = 0; b1.if_addr = 0; b1.d_req = 0; b1.d_we = 0; b1.d_be = 0;
    b1.d_addr = 0; b1.d_wdata = 0;
    b5.if_req = 0; b5.if_addr = 0; b5.d_req = 0; b5.d_we = 0; b5.d_be = 0;
    b5.d_addr = 0; b5.d_wdata = 0; b5.mem_rdata = 32'hBAD0BAD0;

    // Reset values
    tick(); tick();
    chk("rst_mem_en", 64'(b1.mem_en), 64'd0);
    chk("rst_mem_addr", 64'(b1.mem_addr), 64'd0);
    chk("rst_acks", 64'({b1.if_ack, b1.d_ack, b5.if_ack, b5.d_ack}), 64'd0);
    chk("rst_rdata", 64'({b1.if_rdata, b1.d_rdata}), 64'd0);
    resetn = 1'b1;

    // 1: single fetch
    b1.if_req = 1'b1; b1.if_addr = 32'h10;
    tick();
    chk("f1_mem_en", 64'(b1.mem_en), 64'd1);
    chk("f1_mem_addr", 64'(b1.mem_addr), 64'h10);
    chk("f1_mem_we", 64'(b1.mem_we), 64'd0);
    tick();
    chk("f1_c2_ack", 64'({b1.if_ack, b1.d_ack}), 64'd0);
    chk("f1_c2_en", 64'(b1.mem_en), 64'd0);
    tick();
    chk("f1_if_ack", 64'(b1.if_ack), 64'd1);
    chk("f1_if_rdata", 64'(b1.if_rdata), 64'h00500093);
    chk("f1_d_ack", 64'(b1.d_ack), 64'd0);
    b1.if_req = 1'b0;
    tick();
    chk("f1_ack_pulse", 64'(b1.if_ack), 64'd0);

    // 2: full write then read back
    d_txn(1'b1, 4'hF, 32'h100, 32'hDEADBEEF, 4'hF, 32'h0, "wr100");
    d_txn(1'b0, 4'hF, 32'h100, 32'h0, 4'h0, 32'hDEADBEEF, "rd100");

    // 3: partial write, zero-enable write
    d_txn(1'b1, 4'hF, 32'h104, 32'hFFFFFFFF, 4'hF, 32'h0, "wr104");
    d_txn(1'b1, 4'b0101, 32'h104, 32'h11223344, 4'b0101, 32'h0, "wrpart");
    d_txn(1'b0, 4'h0, 32'h104, 32'h0, 4'h0, 32'hFF22FF44, "rdpart");
    d_txn(1'b1, 4'h0, 32'h104, 32'h0, 4'h0, 32'h0, "wrbe0");
    d_txn(1'b0, 4'h0, 32'h104, 32'h0, 4'h0, 32'hFF22FF44, "rdbe0");
    chk("if_rdata_kept", 64'(b1.if_rdata), 64'h00500093);

    // 6: reset during WAIT of a fetch (last grant was fetch before reset)
    b1.if_req = 1'b1; b1.if_addr = 32'h10;
    tick();
    chk("r6_issue", 64'(b1.mem_en), 64'd1);
    tick();
    resetn = 1'b0;
    #1;
    chk("r6_mem_en", 64'(b1.mem_en), 64'd0);
    chk("r6_mem_addr", 64'(b1.mem_addr), 64'd0);
    chk("r6_rdata", 64'({b1.if_rdata, b1.d_rdata}), 64'd0);
    chk("r6_acks", 64'({b1.if_ack, b1.d_ack}), 64'd0);
    b1.d_req = 1'b1; b1.d_we = 1'b0; b1.d_be = 4'h0; b1.d_addr = 32'h104;
    tick(); tick();
    chk("r6_no_ack", 64'({b1.if_ack, b1.d_ack}), 64'd0);
    resetn = 1'b1;

    // 4: continuous contention, fetch first after reset
    tick();
    chk("c_g1_addr", 64'(b1.mem_addr), 64'h10);
    tick(); tick();
    chk("c_g1_acks", 64'({b1.if_ack, b1.d_ack}), 64'b10);
    chk("c_g1_if_rdata", 64'(b1.if_rdata), 64'h00500093);
    b1.if_addr = 32'h14;
    tick(); tick();
    chk("c_g2_addr", 64'(b1.mem_addr), 64'h104);
    tick(); tick();
    chk("c_g2_acks", 64'({b1.if_ack, b1.d_ack}), 64'b01);
    chk("c_g2_d_rdata", 64'(b1.d_rdata), 64'hFF22FF44);
    chk("c_g2_if_kept", 64'(b1.if_rdata), 64'h00500093);
    b1.d_addr = 32'h100;
    tick(); tick();
    chk("c_g3_addr", 64'(b1.mem_addr), 64'h14);
    tick(); tick();
    chk("c_g3_acks", 64'({b1.if_ack, b1.d_ack}), 64'b10);
    chk("c_g3_if_rdata", 64'(b1.if_rdata), 64'h00100113);
    chk("c_g3_d_kept", 64'(b1.d_rdata), 64'hFF22FF44);
    tick(); tick();
    chk("c_g4_addr", 64'(b1.mem_addr), 64'h100);
    tick(); tick();
    chk("c_g4_acks", 64'({b1.if_ack, b1.d_ack}), 64'b01);
    chk("c_g4_d_rdata", 64'(b1.d_rdata), 64'hDEADBEEF);
    chk("c_g4_if_kept", 64'(b1.if_rdata), 64'h00100113);
    b1.if_req = 1'b0; b1.d_req = 1'b0;
    tick();

    // 5: latency-3 read, data valid only in cycle 4
    b5.d_req = 1'b1; b5.d_we = 1'b0; b5.d_be = 4'hF; b5.d_addr = 32'h200;
    tick();
    chk("l3_mem_en", 64'(b5.mem_en), 64'd1);
    chk("l3_mem_addr", 64'(b5.mem_addr), 64'h200);
    chk("l3_mem_we", 64'(b5.mem_we), 64'd0);
    tick();
    chk("l3_en_low", 64'(b5.mem_en), 64'd0);
    tick();
    chk("l3_c3_ack", 64'(b5.d_ack), 64'd0);
    tick();
    b5.mem_rdata = 32'hCAFEF00D;
    chk("l3_c4_ack", 64'(b5.d_ack), 64'd0);
    tick();
    b5.mem_rdata = 32'hBAD0BAD0;
    chk("l3_d_ack", 64'(b5.d_ack), 64'd1);
    chk("l3_d_rdata", 64'(b5.d_rdata), 64'hCAFEF00D);
    chk("l3_if_side", 64'({b5.if_ack, b5.if_rdata}), 64'd0);
    b5.d_req = 1'b0;
    tick();
    chk("l3_ack_pulse", 64'(b5.d_ack), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
